// File: rtl/cpu_pkg.sv
// Shared CPU types: multiply modes, pipe depth limit and mode decode helpers.
package cpu_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,  // MUL: low half
        MUL_HSS = 2'b01,  // MULH: signed x signed, high half
        MUL_HUU = 2'b10,  // MULHU: unsigned x unsigned, high half
        MUL_HSU = 2'b11   // MULHSU: signed x unsigned, high half
    } mul_mode_t;

    localparam int unsigned MUL_MAX_STAGES = 8;

    // Operand A is treated as signed for MULH and MULHSU.
    function automatic logic mul_a_signed(mul_mode_t mode);
        return (mode == MUL_HSS) || (mode == MUL_HSU);
    endfunction

    // Operand B is treated as signed for MULH only.
    function automatic logic mul_b_signed(mul_mode_t mode);
        return mode == MUL_HSS;
    endfunction

    // Every mode except MUL returns the upper half of the product.
    function automatic logic mul_pick_high(mul_mode_t mode);
        return mode != MUL_LO;
    endfunction

endpackage

// File: rtl/cpu_pipe_reg.sv
// One pipeline slot: valid bit plus payload, held by stall, cleared by reset.
module cpu_pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic         d_valid,
    input  logic [W-1:0] d_data,
    output logic         q_valid,
    output logic [W-1:0] q_data
);

    // Advance when not stalled; payload only loads for valid entries to cut toggling.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (!stall) begin
            q_valid <= d_valid;
            if (d_valid) begin
                q_data <= d_data;
            end
        end
    end

endmodule

// File: rtl/cpu_mul_pipe.sv
// Pipelined multiplier for the execute stage with in-flight destination hazard tracking.
module cpu_mul_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned TAG_WIDTH = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 p4_jump_taken,
    input  logic                 p3_start,
    input  mul_mode_t            p3_mode,
    input  logic [WIDTH-1:0]     p3_data_a,
    input  logic [WIDTH-1:0]     p3_data_b,
    input  logic [TAG_WIDTH-1:0] p3_dest,
    input  logic [TAG_WIDTH-1:0] p2_query_a,
    input  logic [TAG_WIDTH-1:0] p2_query_b,
    output logic                 p2_hazard,
    output logic                 busy,
    output logic                 mul_valid,
    output logic [WIDTH-1:0]     mul_result,
    output logic [TAG_WIDTH-1:0] mul_dest
);

    localparam int unsigned EXT_W  = WIDTH + 1;
    localparam int unsigned PROD_W = 2 * EXT_W;
    localparam int unsigned RES_W  = TAG_WIDTH + WIDTH;
    localparam int unsigned OP_W   = 2 + TAG_WIDTH + 2 * EXT_W;

    // Stage 0 payload when the multiply happens after the first register.
    typedef struct packed {
        mul_mode_t            mode;
        logic [TAG_WIDTH-1:0] dest;
        logic [EXT_W-1:0]     a;
        logic [EXT_W-1:0]     b;
    } mul_op_t;

    // Payload of every stage that already holds the selected result.
    typedef struct packed {
        logic [TAG_WIDTH-1:0] dest;
        logic [WIDTH-1:0]     result;
    } mul_res_t;

    if (STAGES == 0 || STAGES > MUL_MAX_STAGES) begin : g_bad_stages
        $error("cpu_mul_pipe: STAGES must be in 1..%0d", MUL_MAX_STAGES);
    end

    // Widen an operand by one bit, replicating the sign only for signed use.
    function automatic logic [EXT_W-1:0] mul_extend(logic [WIDTH-1:0] v, logic sgn);
        return {sgn & v[WIDTH-1], v};
    endfunction

    // One signed (WIDTH+1)-bit multiply covers all four modes; pick the wanted half.
    function automatic logic [WIDTH-1:0] mul_compute(mul_mode_t mode,
                                                     logic [EXT_W-1:0] a,
                                                     logic [EXT_W-1:0] b);
        logic signed [PROD_W-1:0] prod;
        prod = $signed(a) * $signed(b);
        return WIDTH'(prod >> (mul_pick_high(mode) ? WIDTH : 0));
    endfunction

    logic                               issue;
    logic [STAGES-1:0]                  stg_valid;
    logic [STAGES-1:0][TAG_WIDTH-1:0]   stg_dest;
    logic [STAGES-1:0][WIDTH-1:0]       stg_result;
    logic [STAGES-1:0]                  stg_hit;

    // Stalled or nullified ops are dropped at the door.
    assign issue = p3_start & ~stall & ~p4_jump_taken;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            if (STAGES == 1) begin : g_comb_mul
                // Single-stage pipe: multiply straight from the inputs into the only register.
                mul_res_t d;
                mul_res_t q;
                assign d.dest   = p3_dest;
                assign d.result = mul_compute(p3_mode,
                                              mul_extend(p3_data_a, mul_a_signed(p3_mode)),
                                              mul_extend(p3_data_b, mul_b_signed(p3_mode)));
                cpu_pipe_reg #(.W(RES_W)) u_reg (
                    .clock   (clock),
                    .reset   (reset),
                    .stall   (stall),
                    .d_valid (issue),
                    .d_data  (d),
                    .q_valid (stg_valid[0]),
                    .q_data  (q)
                );
                assign stg_dest[0]   = q.dest;
                assign stg_result[0] = q.result;
            end else begin : g_operands
                // Capture extended operands; the multiply sits between stage 0 and stage 1.
                mul_op_t d;
                mul_op_t q;
                assign d.mode = p3_mode;
                assign d.dest = p3_dest;
                assign d.a    = mul_extend(p3_data_a, mul_a_signed(p3_mode));
                assign d.b    = mul_extend(p3_data_b, mul_b_signed(p3_mode));
                cpu_pipe_reg #(.W(OP_W)) u_reg (
                    .clock   (clock),
                    .reset   (reset),
                    .stall   (stall),
                    .d_valid (issue),
                    .d_data  (d),
                    .q_valid (stg_valid[0]),
                    .q_data  (q)
                );
                assign stg_dest[0]   = q.dest;
                assign stg_result[0] = mul_compute(q.mode, q.a, q.b);
            end
        end else begin : g_delay
            // Stage 1 registers the product; later stages are retiming delay.
            mul_res_t d;
            mul_res_t q;
            assign d.dest   = stg_dest[k-1];
            assign d.result = stg_result[k-1];
            cpu_pipe_reg #(.W(RES_W)) u_reg (
                .clock   (clock),
                .reset   (reset),
                .stall   (stall),
                .d_valid (stg_valid[k-1]),
                .d_data  (d),
                .q_valid (stg_valid[k]),
                .q_data  (q)
            );
            assign stg_dest[k]   = q.dest;
            assign stg_result[k] = q.result;
        end
    end

    // Per-stage RAW match; register 0 is never a real dependency.
    for (genvar k = 0; k < STAGES; k++) begin : g_hazard
        assign stg_hit[k] = stg_valid[k] & (stg_dest[k] != '0) &
                            ((stg_dest[k] == p2_query_a) | (stg_dest[k] == p2_query_b));
    end

    assign p2_hazard  = |stg_hit;
    assign busy       = |stg_valid;
    assign mul_valid  = stg_valid[STAGES-1];
    assign mul_result = stg_result[STAGES-1];
    assign mul_dest   = stg_dest[STAGES-1];

endmodule

// File: tb/tb_cpu_mul_pipe.sv
// Directed + random bench for cpu_mul_pipe at STAGES = 1, 3 and 8 driven in parallel.
module tb_cpu_mul_pipe;
    import cpu_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        stall;
    logic        p4_jump_taken;
    logic        p3_start;
    mul_mode_t   p3_mode;
    logic [31:0] p3_data_a;
    logic [31:0] p3_data_b;
    logic [4:0]  p3_dest;
    logic [4:0]  p2_query_a;
    logic [4:0]  p2_query_b;

    logic [2:0]  mv;
    logic [2:0]  bz;
    logic [2:0]  hz;
    logic [31:0] mr [3];
    logic [4:0]  md [3];

    cpu_mul_pipe #(.WIDTH(32), .STAGES(1), .TAG_WIDTH(5)) u_s1 (
        .clock(clock), .reset(reset), .stall(stall), .p4_jump_taken(p4_jump_taken),
        .p3_start(p3_start), .p3_mode(p3_mode), .p3_data_a(p3_data_a), .p3_data_b(p3_data_b),
        .p3_dest(p3_dest), .p2_query_a(p2_query_a), .p2_query_b(p2_query_b),
        .p2_hazard(hz[0]), .busy(bz[0]), .mul_valid(mv[0]), .mul_result(mr[0]), .mul_dest(md[0]));

    cpu_mul_pipe #(.WIDTH(32), .STAGES(3), .TAG_WIDTH(5)) u_s3 (
        .clock(clock), .reset(reset), .stall(stall), .p4_jump_taken(p4_jump_taken),
        .p3_start(p3_start), .p3_mode(p3_mode), .p3_data_a(p3_data_a), .p3_data_b(p3_data_b),
        .p3_dest(p3_dest), .p2_query_a(p2_query_a), .p2_query_b(p2_query_b),
        .p2_hazard(hz[1]), .busy(bz[1]), .mul_valid(mv[1]), .mul_result(mr[1]), .mul_dest(md[1]));

    cpu_mul_pipe #(.WIDTH(32), .STAGES(8), .TAG_WIDTH(5)) u_s8 (
        .clock(clock), .reset(reset), .stall(stall), .p4_jump_taken(p4_jump_taken),
        .p3_start(p3_start), .p3_mode(p3_mode), .p3_data_a(p3_data_a), .p3_data_b(p3_data_b),
        .p3_dest(p3_dest), .p2_query_a(p2_query_a), .p2_query_b(p2_query_b),
        .p2_hazard(hz[2]), .busy(bz[2]), .mul_valid(mv[2]), .mul_result(mr[2]), .mul_dest(md[2]));

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  dest;
    } exp_t;

    exp_t sb[$];
    int   rd[3];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic int stages_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 8);
    endfunction

    // Reference multiply built on 64-bit integer arithmetic.
    function automatic logic [31:0] model(logic [1:0] m, logic [31:0] a, logic [31:0] b);
        longint      sa;
        longint      sb_l;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb_l = longint'($signed(b));
        case (m)
            2'd1:    p = 64'(sa * sb_l);
            2'd3:    p = 64'(sa * longint'({32'b0, b}));
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (m == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(string tag, int inst, logic [63:0] obs, logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s [STAGES=%0d] observed=%h expected=%h", tag, stages_of(inst), obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present_x(logic st, logic [1:0] m, logic [31:0] a, logic [31:0] b,
                             logic [4:0] d, logic jmp, logic stl, logic [31:0] res);
        p3_start      = st;
        p3_mode       = mul_mode_t'(m);
        p3_data_a     = a;
        p3_data_b     = b;
        p3_dest       = d;
        p4_jump_taken = jmp;
        stall         = stl;
        if (st && !stl && !jmp) sb.push_back('{res: res, dest: d});
    endtask

    task automatic present(logic st, logic [1:0] m, logic [31:0] a, logic [31:0] b,
                           logic [4:0] d, logic jmp, logic stl);
        present_x(st, m, a, b, d, jmp, stl, model(m, a, b));
    endtask

    task automatic idle();
        present(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Scoreboard: compare the head on every valid output, retire it when not stalled.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                rd[i] = sb.size();
            end else if (mv[i]) begin
                if (rd[i] >= sb.size()) begin
                    check("spurious_valid", i, 64'(mv[i]), 64'(0));
                end else begin
                    check("result", i, 64'(mr[i]), 64'(sb[rd[i]].res));
                    check("dest", i, 64'(md[i]), 64'(sb[rd[i]].dest));
                    if (!stall) rd[i]++;
                end
            end
        end
    end

    initial begin
        int s;
        int eff;
        logic stl;

        reset      = 1'b1;
        idle();
        p2_query_a = 5'd30;
        p2_query_b = 5'd31;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", i, 64'(mv[i]), 64'(0));
            check("rst_result", i, 64'(mr[i]), 64'(0));
            check("rst_dest", i, 64'(md[i]), 64'(0));
            check("rst_busy", i, 64'(bz[i]), 64'(0));
            check("rst_hazard", i, 64'(hz[i]), 64'(0));
        end
        reset = 1'b0;

        // MUL 7 x -3: valid exactly STAGES cycles after presentation
        present_x(1'b1, 2'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b0, 1'b0, 32'hFFFF_FFEB);
        tick();
        idle();
        for (int j = 0; j < 9; j++) begin
            for (int i = 0; i < 3; i++) begin
                check("latency_valid", i, 64'(mv[i]), 64'(j == stages_of(i) - 1));
                if (j == stages_of(i) - 1) check("latency_result", i, 64'(mr[i]), 64'(32'hFFFF_FFEB));
            end
            tick();
        end

        // High-half modes with known answers
        present_x(1'b1, 2'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0, 1'b0, 32'h4000_0000);
        tick();
        present_x(1'b1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0, 1'b0, 32'hFFFF_FFFE);
        tick();
        present_x(1'b1, 2'd3, 32'hFFFF_FFFF, 32'd2, 5'd8, 1'b0, 1'b0, 32'hFFFF_FFFF);
        tick();
        idle();
        repeat (10) tick();

        // Four back-to-back issues, two-cycle stall mid-stream
        eff = -1;
        for (int j = 0; j < 16; j++) begin
            stl = (j == 5) || (j == 6);
            if (j < 4) present(1'b1, 2'(j), $urandom, $urandom, 5'(j + 1), 1'b0, 1'b0);
            else present(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, stl);
            tick();
            if (!stl) eff++;
            for (int i = 0; i < 3; i++) begin
                s = stages_of(i);
                check("burst_valid", i, 64'(mv[i]), 64'(eff >= s - 1 && eff <= s + 2));
                if (eff >= s - 1 && eff <= s + 2) check("burst_dest", i, 64'(md[i]), 64'(5'(eff - s + 2)));
            end
        end
        idle();

        // Nullified by jump: nothing enters
        present(1'b1, 2'd2, 32'd5, 32'd6, 5'd9, 1'b1, 1'b0);
        tick();
        idle();
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) check("jump_busy", i, 64'(bz[i]), 64'(0));
            tick();
        end

        // Presented during stall: dropped
        present(1'b1, 2'd0, 32'd11, 32'd12, 5'd10, 1'b0, 1'b1);
        tick();
        idle();
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) check("stall_drop_busy", i, 64'(bz[i]), 64'(0));
            tick();
        end

        // Older op in flight survives a jump-nullified and a stalled presentation
        present(1'b1, 2'd0, 32'd123, 32'd456, 5'd11, 1'b0, 1'b0);
        tick();
        present(1'b1, 2'd1, 32'd9, 32'd9, 5'd12, 1'b1, 1'b0);
        tick();
        present(1'b1, 2'd1, 32'd9, 32'd9, 5'd13, 1'b0, 1'b1);
        tick();
        idle();
        repeat (10) tick();

        // Hazard on dest 5 lasts while the op is in flight
        p2_query_a = 5'd5;
        p2_query_b = 5'd9;
        present(1'b1, 2'd0, 32'd3, 32'd4, 5'd5, 1'b0, 1'b0);
        tick();
        idle();
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 3; i++) begin
                check("hazard_dest5", i, 64'(hz[i]), 64'(j <= stages_of(i) - 1));
                check("busy_dest5", i, 64'(bz[i]), 64'(j <= stages_of(i) - 1));
            end
            tick();
        end

        // Dest 0 never raises a hazard, but still returns a result
        p2_query_a = 5'd9;
        p2_query_b = 5'd0;
        present(1'b1, 2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 3; i++) check("hazard_dest0", i, 64'(hz[i]), 64'(0));
            tick();
        end
        p2_query_a = 5'd30;
        p2_query_b = 5'd31;

        // Random traffic with stalls and jumps
        for (int n = 0; n < 40; n++) begin
            present(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom,
                    5'($urandom_range(1, 29)), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 5) == 0));
            tick();
        end
        idle();
        repeat (12) tick();

        // Full pipe, reset together with stall: everything lost
        for (int j = 0; j < 8; j++) begin
            present(1'b1, 2'(j), $urandom, $urandom, 5'(j + 1), 1'b0, 1'b0);
            tick();
        end
        reset = 1'b1;
        present(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            check("reset_valid", i, 64'(mv[i]), 64'(0));
            check("reset_busy", i, 64'(bz[i]), 64'(0));
        end
        repeat (10) tick();

        // Recovery after reset
        present(1'b1, 2'd0, 32'd6, 32'd7, 5'd2, 1'b0, 1'b0);
        tick();
        idle();
        repeat (10) tick();

        for (int i = 0; i < 3; i++) check("drained", i, 64'(rd[i]), 64'(sb.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
